disp_vramrd: RTL and testbench

- AXI4 read master in the ACLK domain that fetches one display frame from VRAM and pushes it into the display FIFO stage.
- Each 64-bit beat carries two 32-bit pixels; the beat is forwarded unchanged as FIFOIN/FIFOWR.
- Sits directly upstream of the display buffer.
- Throttled by BUF_WREADY, which asserts only when the FIFO can absorb one full burst.

---
 rtl/disp_pkg.sv | 25 ++
 rtl/disp_vramrd.sv | 125 ++++++++++++
 tb/tb_disp_vramrd.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM reader: FSM encoding, AXI read
// constants and the frame geometry helpers.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITBUF = 2'd1,
        ADDR    = 2'd2,
        DATA    = 2'd3
    } disp_state_t;

    localparam logic [2:0] AXI_ARSIZE  = 3'b011;  // 8-byte beats
    localparam logic [1:0] AXI_ARBURST = 2'b01;   // INCR
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // One 64-bit beat carries two 32-bit pixels.
    function automatic int calc_beats(input int h_pixels, input int v_lines);
        return (h_pixels * v_lines) / 2;
    endfunction

    function automatic int calc_bursts(input int h_pixels, input int v_lines, input int burst_len);
        return calc_beats(h_pixels, v_lines) / burst_len;
    endfunction

endpackage

// File: rtl/disp_vramrd.sv
// AXI4 read master fetching one display frame from VRAM burst by burst and
// forwarding every beat to the display FIFO, gated by BUF_WREADY.
module disp_vramrd
    import disp_pkg::*;
#(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480,
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              DISPON,
    input  logic              VSTART,
    input  logic [ADDR_W-1:0] DISPADDR,
    input  logic              BUF_WREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [63:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [63:0]       FIFOIN,
    output logic              FIFOWR,
    output logic              BUSY,
    output logic              RD_ERR,
    output disp_state_t       DBG_STATE
);

    localparam int BURSTS     = calc_bursts(H_PIXELS, V_LINES, BURST_LEN);
    localparam int BCNT_W     = $clog2(BURSTS + 1);
    localparam int BEAT_W     = $clog2(BURST_LEN);
    localparam int STEP_BYTES = BURST_LEN * 8;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(STEP_BYTES);
    localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(BURSTS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    disp_state_t       state;
    logic [BCNT_W-1:0] burst_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    assign ARLEN     = 8'(BURST_LEN - 1);
    assign DBG_STATE = state;

    // AXI handshakes: a transfer happens on any ACLK edge where VALID and
    // READY are both high; ARVALID/ARADDR never change while waiting for
    // ARREADY, and only one burst is outstanding at a time.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            FIFOIN    <= '0;
            FIFOWR    <= 1'b0;
            BUSY      <= 1'b0;
            RD_ERR    <= 1'b0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            FIFOWR <= 1'b0;
            case (state)
                IDLE: begin
                    if (VSTART && DISPON) begin
                        ARADDR    <= DISPADDR & ~ALIGN_MASK;
                        burst_cnt <= '0;
                        beat_cnt  <= '0;
                        BUSY      <= 1'b1;
                        RD_ERR    <= 1'b0;
                        state     <= WAITBUF;
                    end
                end
                WAITBUF: begin
                    if (!DISPON) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (BUF_WREADY) begin
                        ARVALID <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (RVALID && RREADY) begin
                        FIFOIN   <= RDATA;
                        FIFOWR   <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (RRESP != RESP_OKAY) begin
                            RD_ERR <= 1'b1;
                        end
                        // RLAST alone closes the burst; beat_cnt is only cross-checked.
                        if (RLAST) begin
                            RREADY    <= 1'b0;
                            ARADDR    <= ARADDR + ADDR_STEP;
                            burst_cnt <= burst_cnt + 1'b1;
                            beat_cnt  <= '0;
                            if (burst_cnt == LAST_BURST || !DISPON) begin
                                BUSY  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= WAITBUF;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rlast_on_last_beat: assert property (@(posedge ACLK) disable iff (!ARESETN)
        (state == DATA && RVALID && RREADY && RLAST) |-> (beat_cnt == LAST_BEAT));

endmodule

// File: tb/tb_disp_vramrd.sv
// Bench for disp_vramrd: a small AXI read slave with a beat scoreboard, and
// one task per scenario checked against an address/beat model of the frame.
`timescale 1ns/1ps
module tb_disp_vramrd;
    import disp_pkg::*;

    localparam int H_PIX = 8;
    localparam int V_LIN = 2;
    localparam int BLEN  = 4;
    localparam int AW    = 32;
    localparam int BEATS = H_PIX * V_LIN / 2;
    localparam int STEP  = BLEN * 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          DISPON = 1'b0;
    logic          VSTART = 1'b0;
    logic [AW-1:0] DISPADDR = '0;
    logic          BUF_WREADY = 1'b0;
    logic          ARREADY = 1'b0;
    logic [63:0]   RDATA = '0;
    logic [1:0]    RRESP = 2'b00;
    logic          RLAST = 1'b0;
    logic          RVALID = 1'b0;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic          ARVALID;
    logic          RREADY;
    logic [63:0]   FIFOIN;
    logic          FIFOWR;
    logic          BUSY;
    logic          RD_ERR;
    disp_state_t   DBG_STATE;

    int total = 0;
    int bad   = 0;

    // Knobs written by the tests, read by the slave.
    int ar_stall_cfg = 0;
    int err_at       = -1;
    bit gaps         = 1'b0;

    // Slave-owned state and logs.
    int            beats_left  = 0;
    int            beat_total  = 0;
    int            stall_cnt   = 0;
    bit            ar_waiting  = 1'b0;
    logic [AW-1:0] last_araddr = '0;
    int            arv_cycles  = 0;
    int            ar_unstable = 0;
    int            wr_count    = 0;
    int            wr_bad      = 0;
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [63:0]   exp_q[$];
    logic [63:0]   exp_v;

    disp_vramrd #(
        .H_PIXELS (H_PIX),
        .V_LINES  (V_LIN),
        .BURST_LEN(BLEN),
        .ADDR_W   (AW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .DISPON    (DISPON),
        .VSTART    (VSTART),
        .DISPADDR  (DISPADDR),
        .BUF_WREADY(BUF_WREADY),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .FIFOIN    (FIFOIN),
        .FIFOWR    (FIFOWR),
        .BUSY      (BUSY),
        .RD_ERR    (RD_ERR),
        .DBG_STATE (DBG_STATE)
    );

    always #5 ACLK = ~ACLK;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Slave acts on the falling edge: DUT outputs seen here are what the next
    // rising edge samples, so a handshake is decided while driving READY/VALID.
    initial begin : axi_slave
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                ARREADY    = 1'b0;
                RVALID     = 1'b0;
                RLAST      = 1'b0;
                RRESP      = 2'b00;
                beats_left = 0;
                stall_cnt  = 0;
                ar_waiting = 1'b0;
                exp_q.delete();
            end else begin
                // Every accepted beat must appear on FIFOIN exactly one cycle later.
                if (FIFOWR) begin
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        wr_bad++;
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (FIFOIN !== exp_v) wr_bad++;
                    end
                end
                if (exp_q.size() != 0) begin
                    wr_bad++;
                    exp_q.delete();
                end
                ARREADY = 1'b0;
                if (ARVALID) begin
                    arv_cycles++;
                    if (ar_waiting && ARADDR !== last_araddr) ar_unstable++;
                    last_araddr = ARADDR;
                    if (stall_cnt < ar_stall_cfg) begin
                        stall_cnt++;
                        ar_waiting = 1'b1;
                    end else begin
                        ARREADY    = 1'b1;
                        stall_cnt  = 0;
                        ar_waiting = 1'b0;
                        ar_addr_q.push_back(ARADDR);
                        ar_len_q.push_back(ARLEN);
                        beats_left = BLEN;
                    end
                end
                RVALID = 1'b0;
                RLAST  = 1'b0;
                RRESP  = 2'b00;
                if (RREADY && beats_left > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                    RVALID = 1'b1;
                    RDATA  = {$urandom, $urandom};
                    RLAST  = (beats_left == 1);
                    RRESP  = (beat_total == err_at) ? 2'b10 : 2'b00;
                    exp_q.push_back(RDATA);
                    beats_left--;
                    beat_total++;
                end
            end
        end
    end

    // Reference: burst i of a frame reads from the base rounded down to a
    // burst boundary plus i bursts, modulo 2^32.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
        return (base - (base % STEP)) + AW'(i * STEP);
    endfunction

    function automatic logic [AW-1:0] ar_at(input int i);
        return (ar_addr_q.size() > i) ? ar_addr_q[i] : 'x;
    endfunction

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        DISPADDR = base;
        DISPON   = 1'b1;
        VSTART   = 1'b1;
        step();
        VSTART   = 1'b0;
    endtask

    task automatic wait_wr(input int n);
        for (int k = 0; k < 400 && wr_count < n; k++) step();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1000 && (BUSY || beats_left != 0); k++) step();
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) step();
        total++;
        if ({ARVALID, RREADY, FIFOWR, BUSY, RD_ERR} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {ARVALID, RREADY, FIFOWR, BUSY, RD_ERR});
        end
        total++;
        if (ARADDR !== '0 || FIFOIN !== '0) begin
            bad++; $display("FAIL reset_data: araddr=%h fifoin=%h want 0", ARADDR, FIFOIN);
        end
        total++;
        if (DBG_STATE !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", DBG_STATE, IDLE);
        end
        total++;
        if (ARLEN !== 8'(BLEN - 1)) begin
            bad++; $display("FAIL arlen_const: got %0d want %0d", ARLEN, BLEN - 1);
        end
        ARESETN = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int a0 = ar_addr_q.size();
        int w0 = wr_count;
        int b0 = wr_bad;
        BUF_WREADY = 1'b1;
        gaps = 1'b0;
        start_frame(32'h2000_0000);
        for (int k = 0; k < 300 && (wr_count - w0) < BEATS; k++) step();
        total++;
        if (wr_count - w0 != BEATS) begin
            bad++; $display("FAIL single_wr_count: got %0d want %0d", wr_count - w0, BEATS);
        end
        total++;
        if ({BUSY, FIFOWR} !== 2'b01) begin
            bad++; $display("FAIL single_busy_at_last: busy,fifowr=%b want 01", {BUSY, FIFOWR});
        end
        total++;
        if (ar_addr_q.size() - a0 != 2) begin
            bad++; $display("FAIL single_ar_count: got %0d want 2", ar_addr_q.size() - a0);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ar_at(a0 + i) !== exp_addr(32'h2000_0000, i)) begin
                bad++; $display("FAIL single_araddr%0d: got %h want %h", i, ar_at(a0 + i), exp_addr(32'h2000_0000, i));
            end
            total++;
            if (ar_len_q.size() <= a0 + i || ar_len_q[a0 + i] !== 8'(BLEN - 1)) begin
                bad++; $display("FAIL single_arlen%0d: want %0d", i, BLEN - 1);
            end
        end
        total++;
        if (wr_bad != b0) begin
            bad++; $display("FAIL single_fifo_data: errors=%0d want 0", wr_bad - b0);
        end
        step();
        total++;
        if (DBG_STATE !== IDLE) begin
            bad++; $display("FAIL single_end_state: got %0d want %0d", DBG_STATE, IDLE);
        end
    endtask

    task automatic test_backpressure();
        int a0 = ar_addr_q.size();
        int w0 = wr_count;
        int b0 = wr_bad;
        int hi = 0;
        logic [AW-1:0] base = $urandom;
        gaps = 1'b1;
        BUF_WREADY = 1'b1;
        start_frame(base);
        for (int k = 0; k < 100 && ar_addr_q.size() == a0; k++) step();
        BUF_WREADY = 1'b0;
        wait_wr(w0 + BLEN);
        total++;
        if (wr_count - w0 != BLEN) begin
            bad++; $display("FAIL bp_first_burst: got %0d beats want %0d", wr_count - w0, BLEN);
        end
        for (int k = 0; k < 50; k++) begin
            step();
            if (ARVALID) hi++;
        end
        total++;
        if (hi != 0 || ar_addr_q.size() - a0 != 1) begin
            bad++; $display("FAIL bp_hold: arvalid_cycles=%0d ars=%0d want 0 and 1", hi, ar_addr_q.size() - a0);
        end
        total++;
        if (DBG_STATE !== WAITBUF || BUSY !== 1'b1) begin
            bad++; $display("FAIL bp_state: state=%0d busy=%b want %0d 1", DBG_STATE, BUSY, WAITBUF);
        end
        BUF_WREADY = 1'b1;
        total++;
        if (ARVALID !== 1'b0) begin
            bad++; $display("FAIL bp_ar_early: got %b want 0", ARVALID);
        end
        step();
        total++;
        if (ARVALID !== 1'b1) begin
            bad++; $display("FAIL bp_ar_issue: got %b want 1", ARVALID);
        end
        wait_idle();
        total++;
        if (BUSY !== 1'b0 || wr_count - w0 != BEATS || wr_bad != b0) begin
            bad++; $display("FAIL bp_frame: busy=%b beats=%0d errs=%0d want 0 %0d 0", BUSY, wr_count - w0, wr_bad - b0, BEATS);
        end
        total++;
        if (ar_at(a0 + 1) !== exp_addr(base, 1)) begin
            bad++; $display("FAIL bp_araddr1: got %h want %h", ar_at(a0 + 1), exp_addr(base, 1));
        end
        gaps = 1'b0;
    endtask

    task automatic test_ar_stall();
        int a0 = ar_addr_q.size();
        int v0 = arv_cycles;
        int u0 = ar_unstable;
        int w0 = wr_count;
        ar_stall_cfg = 5;
        start_frame(32'h2000_0013);
        wait_idle();
        ar_stall_cfg = 0;
        total++;
        if (ar_addr_q.size() - a0 != 2 || arv_cycles - v0 != 12) begin
            bad++; $display("FAIL stall_handshakes: ars=%0d arvalid_cycles=%0d want 2 12", ar_addr_q.size() - a0, arv_cycles - v0);
        end
        total++;
        if (ar_unstable != u0) begin
            bad++; $display("FAIL stall_addr_stable: changes=%0d want 0", ar_unstable - u0);
        end
        total++;
        if (ar_at(a0) !== exp_addr(32'h2000_0013, 0)) begin
            bad++; $display("FAIL misaligned_base: got %h want %h", ar_at(a0), exp_addr(32'h2000_0013, 0));
        end
        total++;
        if (wr_count - w0 != BEATS || BUSY !== 1'b0) begin
            bad++; $display("FAIL stall_frame: beats=%0d busy=%b want %0d 0", wr_count - w0, BUSY, BEATS);
        end
    endtask

    task automatic test_addr_wrap();
        int a0 = ar_addr_q.size();
        logic [AW-1:0] base = 32'hFFFF_FFF3;
        start_frame(base);
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ar_at(a0 + i) !== exp_addr(base, i)) begin
                bad++; $display("FAIL wrap_araddr%0d: got %h want %h", i, ar_at(a0 + i), exp_addr(base, i));
            end
        end
    endtask

    task automatic test_dispon_drop();
        int a0 = ar_addr_q.size();
        int w0 = wr_count;
        int b0 = wr_bad;
        BUF_WREADY = 1'b1;
        start_frame($urandom);
        VSTART = 1'b1;
        step();
        VSTART = 1'b0;
        wait_wr(w0 + 1);
        DISPON = 1'b0;
        wait_idle();
        total++;
        if (wr_count - w0 != BLEN || wr_bad != b0) begin
            bad++; $display("FAIL drop_beats: beats=%0d errs=%0d want %0d 0", wr_count - w0, wr_bad - b0, BLEN);
        end
        total++;
        if (BUSY !== 1'b0 || DBG_STATE !== IDLE) begin
            bad++; $display("FAIL drop_idle: busy=%b state=%0d want 0 %0d", BUSY, DBG_STATE, IDLE);
        end
        DISPON = 1'b1;
        repeat (20) step();
        total++;
        if (ar_addr_q.size() - a0 != 1) begin
            bad++; $display("FAIL drop_ar_count: got %0d want 1", ar_addr_q.size() - a0);
        end
        // DISPON falling while waiting for buffer space: straight back to IDLE.
        BUF_WREADY = 1'b0;
        start_frame($urandom);
        step();
        total++;
        if (DBG_STATE !== WAITBUF) begin
            bad++; $display("FAIL waitbuf_state: got %0d want %0d", DBG_STATE, WAITBUF);
        end
        DISPON = 1'b0;
        step();
        total++;
        if (DBG_STATE !== IDLE || BUSY !== 1'b0) begin
            bad++; $display("FAIL waitbuf_drop: state=%0d busy=%b want %0d 0", DBG_STATE, BUSY, IDLE);
        end
        VSTART = 1'b1;
        step();
        VSTART = 1'b0;
        step();
        total++;
        if (BUSY !== 1'b0 || ar_addr_q.size() - a0 != 1) begin
            bad++; $display("FAIL vstart_dispoff: busy=%b ars=%0d want 0 1", BUSY, ar_addr_q.size() - a0);
        end
        BUF_WREADY = 1'b1;
    endtask

    task automatic test_rd_err();
        int w0 = wr_count;
        int b0 = wr_bad;
        logic [AW-1:0] base = $urandom;
        err_at = beat_total + 2;
        start_frame(base);
        wait_wr(w0 + 2);
        total++;
        if (RD_ERR !== 1'b0) begin
            bad++; $display("FAIL err_before: got %b want 0", RD_ERR);
        end
        wait_wr(w0 + 3);
        total++;
        if (RD_ERR !== 1'b1) begin
            bad++; $display("FAIL err_set: got %b want 1", RD_ERR);
        end
        wait_idle();
        total++;
        if (RD_ERR !== 1'b1 || wr_count - w0 != BEATS || wr_bad != b0) begin
            bad++; $display("FAIL err_sticky: rd_err=%b beats=%0d errs=%0d want 1 %0d 0", RD_ERR, wr_count - w0, wr_bad - b0, BEATS);
        end
        w0 = wr_count;
        err_at = beat_total + 5;
        start_frame(base);
        total++;
        if (RD_ERR !== 1'b0) begin
            bad++; $display("FAIL err_clear_on_start: got %b want 0", RD_ERR);
        end
        wait_wr(w0 + 6);
        total++;
        if (RD_ERR !== 1'b1 || BUSY !== 1'b1) begin
            bad++; $display("FAIL err_mid_frame: rd_err=%b busy=%b want 1 1", RD_ERR, BUSY);
        end
        ARESETN = 1'b0;
        #1;
        total++;
        if ({ARVALID, RREADY, FIFOWR, BUSY, RD_ERR} !== 5'b0 || ARADDR !== '0 || FIFOIN !== '0) begin
            bad++; $display("FAIL async_reset: flags=%b araddr=%h fifoin=%h want all 0",
                            {ARVALID, RREADY, FIFOWR, BUSY, RD_ERR}, ARADDR, FIFOIN);
        end
        total++;
        if (DBG_STATE !== IDLE) begin
            bad++; $display("FAIL async_reset_state: got %0d want %0d", DBG_STATE, IDLE);
        end
        repeat (2) step();
        ARESETN = 1'b1;
        err_at = -1;
        step();
        total++;
        if (RD_ERR !== 1'b0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL after_reset: rd_err=%b busy=%b want 0 0", RD_ERR, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_ar_stall();
        test_addr_wrap();
        test_dispon_drop();
        test_rd_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
